// File: rtl/tiny_proc_pkg.sv
// ----------------------------------------------------------------------------
// tiny_proc_pkg
//   Shared definitions for the tiny 4-bit processor run/debug controller:
//   host command opcodes, run_state encodings, default widths and the
//   per-cycle action bundle the controller FSM hands to its datapath.
// ----------------------------------------------------------------------------
package tiny_proc_pkg;

   localparam int PC_W_DEF   = 4;    // program address width
   localparam int INST_W_DEF = 8;    // {opcode[7:4], imm[3:0]}
   localparam int CNT_W_DEF  = 16;   // retired-instruction counter width

   typedef enum logic [2:0] {
      CMD_NOP    = 3'b000,
      CMD_WRITE  = 3'b001,
      CMD_RUN    = 3'b010,
      CMD_HALT   = 3'b011,
      CMD_STEP   = 3'b100,
      CMD_SETBP  = 3'b101,
      CMD_CLRBP  = 3'b110,
      CMD_CPURST = 3'b111
   } cmd_op_e;

   typedef enum logic [2:0] {
      RS_HALTED    = 3'b000,
      RS_RUN       = 3'b001,
      RS_STEP      = 3'b010,
      RS_HALT_PEND = 3'b011,
      RS_CPURST    = 3'b100
   } run_state_e;

   // Datapath side effects decided by the FSM output logic each cycle.
   typedef struct packed {
      logic ram_we;     // write cmd_data into program RAM
      logic bp_set;     // load breakpoint address, arm it
      logic bp_clr;     // disarm breakpoint
      logic hit_set;    // breakpoint just stopped the core
      logic hit_clr;    // clear sticky breakpoint-hit flag
      logic cnt_clr;    // zero the retire counter
      logic cnt_inc;    // count one retired instruction
      logic err;        // accepted command is illegal here
   } ctrl_act_t;

   // Commands the host may not issue while the core is free-running.
   function automatic logic cmd_illegal_in_run(input cmd_op_e op);
      return (op == CMD_WRITE) || (op == CMD_RUN) ||
             (op == CMD_STEP)  || (op == CMD_CPURST);
   endfunction

endpackage

// File: rtl/tiny_prog_ram.sv
// ----------------------------------------------------------------------------
// tiny_prog_ram
//   2**AW x DW program store for the tiny processor.
//   Asynchronous clear to all-zero, synchronous write, combinational read.
// Ports
//   i_clock    write clock
//   i_reset_n  async active-low clear of every word
//   i_we       write enable
//   i_waddr    write address
//   i_wdata    write data
//   i_raddr    read address (core fetch PC)
//   o_rdata    combinational read data
// ----------------------------------------------------------------------------
module tiny_prog_ram
   import tiny_proc_pkg::*;
#(
   parameter int AW = PC_W_DEF,
   parameter int DW = INST_W_DEF
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DEPTH-1:0][DW-1:0] r_mem;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_mem <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tiny_proc_run_ctrl.sv
// ----------------------------------------------------------------------------
// tiny_proc_run_ctrl
//   Run/debug controller for the tiny 4-bit processor. Owns the program RAM,
//   gates core progress with an instruction-granular clock enable
//   (RUN / HALT / single STEP / one PC breakpoint) and counts retirements.
// Ports
//   i_clock, i_reset_n     clock, async active-low reset
//   i_cmd_valid/o_cmd_ready host command handshake
//   i_cmd_op/addr/data     command opcode, RAM or breakpoint address, data
//   o_cmd_err              1-cycle pulse after an illegal accepted command
//   i_cpu_fetch_addr       core PC; o_cpu_fetch_data is RAM[PC] (comb)
//   i_cpu_retire           core write-back cycle marker
//   i_cpu_next_pc          PC the core commits in that write-back cycle
//   o_cpu_en, o_cpu_rst_n  registered core enable / core reset
//   o_run_state            controller state
//   o_bp_hit               sticky "halted by breakpoint"
//   o_instr_count          saturating retired-instruction count
// ----------------------------------------------------------------------------
module tiny_proc_run_ctrl
   import tiny_proc_pkg::*;
#(
   parameter int PC_W   = PC_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [2:0]        i_cmd_op,
   input  logic [PC_W-1:0]   i_cmd_addr,
   input  logic [INST_W-1:0] i_cmd_data,
   output logic              o_cmd_err,
   input  logic [PC_W-1:0]   i_cpu_fetch_addr,
   output logic [INST_W-1:0] o_cpu_fetch_data,
   input  logic              i_cpu_retire,
   input  logic [PC_W-1:0]   i_cpu_next_pc,
   output logic              o_cpu_en,
   output logic              o_cpu_rst_n,
   output logic [2:0]        o_run_state,
   output logic              o_bp_hit,
   output logic [CNT_W-1:0]  o_instr_count
);

   run_state_e        r_state, w_state_nxt;
   logic              r_boot;        // first clock after reset runs a core reset
   logic              r_cpu_en;
   logic              r_cpu_rst_n;
   logic              r_cmd_err;
   logic              r_bp_valid;
   logic [PC_W-1:0]   r_bp_addr;
   logic              r_bp_hit;
   logic [CNT_W-1:0]  r_instr_count;

   cmd_op_e           w_op;
   logic              w_cmd_ready;
   logic              w_accept;
   logic              w_retire;
   logic              w_bp_match;
   logic              w_core_active;
   ctrl_act_t         w_act;

   assign w_op        = cmd_op_e'(i_cmd_op);
   assign w_cmd_ready = !r_boot && ((r_state == RS_HALTED) || (r_state == RS_RUN));
   assign w_accept    = i_cmd_valid && w_cmd_ready;
   // Retire only counts while the core is actually enabled.
   assign w_retire    = i_cpu_retire && r_cpu_en;
   // Compare the PC being committed, so resuming from a parked breakpoint
   // address executes that instruction before the compare can fire again.
   assign w_bp_match  = r_bp_valid && (i_cpu_next_pc == r_bp_addr);
   assign w_core_active = (r_state == RS_RUN) || (r_state == RS_STEP) ||
                          (r_state == RS_HALT_PEND);

   // ---------------------------------------------------------------- state
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= RS_HALTED;
         r_boot  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_boot  <= 1'b0;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      w_state_nxt = r_state;
      if (r_boot) begin
         w_state_nxt = RS_CPURST;
      end else begin
         case (r_state)
            RS_HALTED: begin
               if (w_accept) begin
                  case (w_op)
                     CMD_RUN:    w_state_nxt = RS_RUN;
                     CMD_STEP:   w_state_nxt = RS_STEP;
                     CMD_CPURST: w_state_nxt = RS_CPURST;
                     default:    w_state_nxt = RS_HALTED;
                  endcase
               end
            end
            RS_RUN: begin
               if (w_retire && w_bp_match) begin
                  w_state_nxt = RS_HALTED;
               end else if (w_accept && (w_op == CMD_HALT)) begin
                  // A halt landing on a write-back cycle stops right there.
                  w_state_nxt = w_retire ? RS_HALTED : RS_HALT_PEND;
               end
            end
            RS_STEP, RS_HALT_PEND: begin
               if (w_retire) w_state_nxt = RS_HALTED;
            end
            RS_CPURST: w_state_nxt = RS_HALTED;
            default:   w_state_nxt = RS_HALTED;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   always_comb begin
      w_act         = '0;
      w_act.ram_we  = w_accept && (r_state == RS_HALTED) && (w_op == CMD_WRITE);
      w_act.bp_set  = w_accept && (w_op == CMD_SETBP);
      w_act.bp_clr  = w_accept && (w_op == CMD_CLRBP);
      w_act.err     = w_accept && (r_state == RS_RUN) && cmd_illegal_in_run(w_op);
      w_act.cnt_inc = w_retire && w_core_active;
      w_act.cnt_clr = (w_state_nxt == RS_CPURST);
      w_act.hit_set = (r_state == RS_RUN) && w_retire && w_bp_match;
      w_act.hit_clr = w_act.cnt_clr || w_act.bp_clr ||
                      ((r_state == RS_HALTED) &&
                       ((w_state_nxt == RS_RUN) || (w_state_nxt == RS_STEP)));
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cpu_en      <= 1'b0;
         r_cpu_rst_n   <= 1'b0;
         r_cmd_err     <= 1'b0;
         r_bp_valid    <= 1'b0;
         r_bp_addr     <= '0;
         r_bp_hit      <= 1'b0;
         r_instr_count <= '0;
      end else begin
         // Enable drops on the edge that samples the final retire, so the
         // write-back completes and the next fetch never starts.
         r_cpu_en    <= (w_state_nxt == RS_RUN) || (w_state_nxt == RS_STEP) ||
                        (w_state_nxt == RS_HALT_PEND);
         r_cpu_rst_n <= (w_state_nxt != RS_CPURST);
         r_cmd_err   <= w_act.err;

         if (w_act.bp_set) begin
            r_bp_valid <= 1'b1;
            r_bp_addr  <= i_cmd_addr;
         end else if (w_act.bp_clr) begin
            r_bp_valid <= 1'b0;
         end

         // A stop that actually happened outranks a same-cycle clear, so
         // the host can always tell why the core parked.
         if (w_act.hit_set)      r_bp_hit <= 1'b1;
         else if (w_act.hit_clr) r_bp_hit <= 1'b0;

         if (w_act.cnt_clr) begin
            r_instr_count <= '0;
         end else if (w_act.cnt_inc && !(&r_instr_count)) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
         end
      end
   end

   tiny_prog_ram #(
      .AW (PC_W),
      .DW (INST_W)
   ) u_ram (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_we      (w_act.ram_we),
      .i_waddr   (i_cmd_addr),
      .i_wdata   (i_cmd_data),
      .i_raddr   (i_cpu_fetch_addr),
      .o_rdata   (o_cpu_fetch_data)
   );

   assign o_cmd_ready   = w_cmd_ready;
   assign o_cmd_err     = r_cmd_err;
   assign o_cpu_en      = r_cpu_en;
   assign o_cpu_rst_n   = r_cpu_rst_n;
   assign o_run_state   = r_state;
   assign o_bp_hit      = r_bp_hit;
   assign o_instr_count = r_instr_count;

endmodule
